// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer: FSM state encoding,
// bit-counter width and the even-parity helper used by SIPO_PARITY_EN builds.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int SIPO_MAX_WIDTH = 32;
  // Sized for the widest legal word so the counter can also hold WIDTH itself.
  localparam int SIPO_CNT_W = $clog2(SIPO_MAX_WIDTH + 1);

  function automatic logic even_parity(input logic [SIPO_MAX_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
// A word completing while an undelivered word is held and not accepted is dropped.
module sipo_out_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_i,
  input  logic             perr_i,
  input  logic             complete_i,
  input  logic             q_ready_i,
  input  logic             clr_overrun_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = clr_overrun_i ? 1'b0 : ovr_q;
    if (complete_i) begin
      if (!valid_q || q_ready_i) begin
        q_d     = word_i;
        perr_d  = perr_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;  // drop wins over a same-edge clear
      end
    end else if (valid_q && q_ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign q_o          = q_q;
  assign q_valid_o    = valid_q;
  assign overrun_o    = ovr_q;
  assign parity_err_o = perr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Framed serial-in parallel-out deserializer feeding a valid/ready holding register.
// Define SIPO_PARITY_EN to append an even-parity bit to every word.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             parity_err
);

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        sreg_q, sreg_d;
  logic [SIPO_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]        shifted, first_word, word;
  logic                    last_bit, complete, word_perr;

  // A framed restart is simply a shift into an all-zero register.
  always_comb begin
    if (MSB_FIRST) begin
      shifted    = {sreg_q[WIDTH-2:0], sin};
      first_word = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      shifted    = {sin, sreg_q[WIDTH-1:1]};
      first_word = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  assign last_bit = (cnt_q == SIPO_CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (sin_valid) begin
      if (frame) begin
        state_d = SHIFT;
        sreg_d  = first_word;
        cnt_d   = SIPO_CNT_W'(1);
      end else begin
        case (state_q)
          SHIFT: begin
            sreg_d = shifted;
            cnt_d  = cnt_q + SIPO_CNT_W'(1);
            if (last_bit) begin
`ifdef SIPO_PARITY_EN
              state_d = PARITY;
`else
              state_d = IDLE;
              cnt_d   = '0;
`endif
            end
          end
`ifdef SIPO_PARITY_EN
          PARITY: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    complete  = 1'b0;
    word      = shifted;
    word_perr = 1'b0;
`ifdef SIPO_PARITY_EN
    word      = sreg_q;
    complete  = sin_valid && !frame && (state_q == PARITY);
    word_perr = even_parity(SIPO_MAX_WIDTH'(sreg_q)) ^ sin;
`else
    complete  = sin_valid && !frame && (state_q == SHIFT) && last_bit;
`endif
  end

  sipo_out_buffer #(.WIDTH(WIDTH)) u_out (
    .clk          (clk),
    .reset        (reset),
    .word_i       (word),
    .perr_i       (word_perr),
    .complete_i   (complete),
    .q_ready_i    (q_ready),
    .clr_overrun_i(clr_overrun),
    .q_o          (q),
    .q_valid_o    (q_valid),
    .overrun_o    (overrun),
    .parity_err_o (parity_err)
  );

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in parallel-out deserializer. It is the receive-side counterpart of the team's PISO shift register.
- Collects a framed serial bitstream into WIDTH-bit words and presents each word on a valid/ready output holding register.
- Sits between a serial link and parallel consumer logic.
- Provides frame resync, backpressure and overrun detection.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 1, 1: first received bit lands in q[WIDTH-1]; 0: first received bit lands in q[0].

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
sin  input  1  serial data bit.
sin_valid  input  1  qualifies sin; the bit is sampled only on edges where sin_valid=1.
frame  input  1  with sin_valid=1, marks sin as the first bit of a new word.
q  output  WIDTH  assembled word, output holding register.
q_valid  output  1  q holds an undelivered word.
q_ready  input  1  consumer accepts q when q_valid=1 and q_ready=1.
busy  output  1  a partial word is in progress (state not IDLE).
overrun  output  1  sticky: a completed word was dropped.
clr_overrun  input  1  synchronous clear of overrun.
parity_err  output  1  parity result for the word in q; tied 0 without the macro.

Behaviour:
- Reset (async, immediate): state=IDLE, shift register=0, bit count=0, q=0, q_valid=0, overrun=0, parity_err=0, busy=0.
- Reset mid-word discards the partial word and any held word.
- States:
  - IDLE: waits for a bit with sin_valid=1 and frame=1, then loads it as bit 1 and goes to SHIFT. Bits with frame=0 are ignored in IDLE.
  - SHIFT: each bit with sin_valid=1 is shifted in and the count increments.
  - SHIFT resync: frame=1 discards the partial word and restarts with that bit as bit 1. No error is flagged.
  - Completion: on the WIDTH-th bit, the word completes and the state returns to IDLE. With the parity macro, the state goes to PARITY instead.
  - PARITY (macro only): is covered under Optional Feature.
- sin_valid=0: all state holds, and gaps of any length between bits are legal.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Latency: q and q_valid update on the edge that samples the final bit. They are visible in the following cycle.
- Output handshake:
  - q stays stable while q_valid=1 and q_ready=0.
  - q_valid drops on an edge where q_valid=1 and q_ready=1, unless a new word completes on that same edge.
- Completion with q_valid=0, or with q_valid=1 and q_ready=1: the new word loads into q and q_valid is 1.
- Completion with q_valid=1 and q_ready=0: the new word is dropped, q is unchanged, and overrun is set.
- overrun set and clr_overrun on the same edge: set wins.
- busy=1 in SHIFT and PARITY.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY and waits for one more valid bit, the even-parity bit.
  - The word is delivered on that edge with parity_err = XOR(data bits, parity bit). parity_err is held with q.
  - A mismatched word is still delivered.
  - frame=1 in PARITY resyncs as in SHIFT.
- Undefined: no PARITY state, the word is delivered after WIDTH bits, and parity_err is constant 0.

Decomposition:
- sipo_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - a localparam for the counter width, $clog2(WIDTH+1);
  - a function computing even parity.
- One sub-module, sipo_out_buffer, holds the holding register with the valid/ready handshake and overrun logic. Its input is a word plus a complete strobe.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: send 1,0,1,0,1,0,1,0 with frame on the first bit and q_ready=1 -> q=8'hAA, q_valid high for one cycle after the 8th bit, overrun=0.
2. Same bits with MSB_FIRST=0 -> q=8'h55.
3. q_ready=0: send 0xAA then 0x0F -> q stays 0xAA with q_valid=1, overrun=1. Then q_ready=1 -> q_valid drops. Then clr_overrun -> overrun=0.
4. Send 3 bits, then frame=1 followed by 8 bits of 0xF0 -> exactly one q_valid pulse, q=0xF0. Insert random sin_valid=0 gaps -> identical result.
5. Assert reset after 5 bits -> all outputs 0 immediately, busy=0. A subsequent framed 0x3C is received correctly.
6. With SIPO_PARITY_EN: 0xAA + parity 0 -> parity_err=0; 0xAB + parity 0 -> parity_err=1, q=0xAB.
